count_mode_ctrl: RTL and testbench

- Run/pause/direction/speed controller for the 2-digit BCD counter (00-99) and the 8-digit 7-segment display path.
- Debounces three front-panel buttons and runs a 4-state FSM.
- Selects one of four rate ticks from the clock-enable divider and issues single-cycle count, direction and clear commands to the counter.
- Drives the digit-enable mask so the display blinks while paused.

---
 rtl/count_mode_ctrl.sv | 94 +++++++++
 tb/tb_count_mode_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/count_mode_ctrl.sv
// count_mode_ctrl: run/pause/direction/speed controller for a 2-digit BCD counter and blinking display
module count_mode_ctrl #(
  parameter int unsigned DB_CNT   = 20,
  parameter bit          AUTO_REV = 1'b0,
  parameter logic [7:0]  ENA_MASK = 8'h03
) (
  input  logic       ckht,
  input  logic       rst,
  input  logic       ena1khz,
  input  logic       ena10hz,
  input  logic       ena5hz,
  input  logic       ena2hz,
  input  logic       ena1hz,
  input  logic       btn_run,
  input  logic       btn_mode,
  input  logic       btn_dir,
  input  logic [3:0] donvi,
  input  logic [3:0] chuc,
  output logic       ena_db,
  output logic       dir_up,
  output logic       clr,
  output logic [1:0] speed_sel,
  output logic [1:0] state,
  output logic [7:0] ena_8led
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN_UP = 2'd1, RUN_DN = 2'd2, PAUSE = 2'd3} state_t;
  localparam logic [7:0] DB = 8'(DB_CNT);
  state_t state_q, state_d, run_next;
  logic [2:0] raw, lvl_q, lvl_d, press_q;
  logic [7:0] cnt_q [3];
  logic [7:0] cnt_d [3];
  logic [1:0] speed_q, speed_d;
  logic dir_q, dir_d, db_q, db_d, clr_q, clr_d;
  logic [7:0] led_q, led_d;
  logic [3:0] ticks;
  logic tick_sel, running, at_lim, clr_req;
  assign raw = {btn_dir, btn_mode, btn_run};
  assign ticks = {ena1hz, ena2hz, ena5hz, ena10hz};
  assign tick_sel = ticks[speed_q];
  assign running = state_q == RUN_UP || state_q == RUN_DN;
  assign at_lim = AUTO_REV && running && tick_sel && (dir_q ? {chuc, donvi} == 8'h99 : {chuc, donvi} == 8'h00);
  assign clr_req = press_q[0] & press_q[2];
  // Debounce: a new level is accepted only after DB consecutive differing 1 kHz samples
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (ena1khz) begin
        cnt_d[i] = (raw[i] == lvl_q[i] || cnt_q[i] + 8'd1 == DB) ? 8'd0 : cnt_q[i] + 8'd1;
        lvl_d[i] = (raw[i] != lvl_q[i] && cnt_q[i] + 8'd1 == DB) ? raw[i] : lvl_q[i];
      end
    end
  end
  // Control: clear request dominates, limit reversal beats a manual direction press
  always_comb begin
    speed_d = speed_q + {1'b0, press_q[1]};
    dir_d = clr_req ? 1'b1 : (at_lim | press_q[2]) ? ~dir_q : dir_q;
    run_next = dir_d ? RUN_UP : RUN_DN;
    state_d = clr_req ? IDLE : press_q[0] ? (running ? PAUSE : run_next) : running ? run_next : state_q;
    db_d = running & tick_sel & ~at_lim & ~clr_req;
    clr_d = clr_req;
    led_d = state_d != PAUSE ? ENA_MASK : (state_q == PAUSE && ena2hz) ? (led_q == 8'h00 ? ENA_MASK : 8'h00) : led_q;
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge ckht) begin
    if (!rst) begin
      lvl_q <= '0;
      press_q <= '0;
      cnt_q <= '{default: '0};
      state_q <= IDLE;
      speed_q <= '0;
      dir_q <= 1'b1;
      db_q <= 1'b0;
      clr_q <= 1'b0;
      led_q <= ENA_MASK;
    end else begin
      lvl_q <= lvl_d;
      press_q <= lvl_d & ~lvl_q;
      cnt_q <= cnt_d;
      state_q <= state_d;
      speed_q <= speed_d;
      dir_q <= dir_d;
      db_q <= db_d;
      clr_q <= clr_d;
      led_q <= led_d;
    end
  end
  assign ena_db = db_q;
  assign dir_up = dir_q;
  assign clr = clr_q;
  assign speed_sel = speed_q;
  assign state = state_q;
  assign ena_8led = led_q;
endmodule

// File: tb/tb_count_mode_ctrl.sv
// tb_count_mode_ctrl: directed bench with a cycle-level behavioural model of the controller
module tb_count_mode_ctrl;
  localparam int DB = 4;
  logic ckht = 0, rst = 0;
  logic ena1khz = 0, ena10hz = 0, ena5hz = 0, ena2hz = 0, ena1hz = 0;
  logic btn_run = 0, btn_mode = 0, btn_dir = 0;
  logic [3:0] donvi = 4'd5, chuc = 4'd5;
  logic ena_db, dir_up, clr;
  logic [1:0] speed_sel, state;
  logic [7:0] ena_8led;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  count_mode_ctrl #(.DB_CNT(DB), .AUTO_REV(1'b1), .ENA_MASK(8'h03)) dut (
    .ckht(ckht), .rst(rst), .ena1khz(ena1khz), .ena10hz(ena10hz), .ena5hz(ena5hz),
    .ena2hz(ena2hz), .ena1hz(ena1hz), .btn_run(btn_run), .btn_mode(btn_mode), .btn_dir(btn_dir),
    .donvi(donvi), .chuc(chuc), .ena_db(ena_db), .dir_up(dir_up), .clr(clr),
    .speed_sel(speed_sel), .state(state), .ena_8led(ena_8led)
  );

  always #5 ckht = ~ckht;

  // Model: phase 0 = idle, 1 = running, 2 = paused; direction and lit flag kept separately
  int m_phase = 0, m_speed = 0, m_cnt[3] = '{0, 0, 0};
  bit m_up = 1, m_db = 0, m_clr = 0, m_lit = 1;
  bit [2:0] m_lvl = 0, m_press = 0;
  always @(posedge ckht) begin
    bit [2:0] r, nl, ev;
    bit [3:0] tk;
    bit tick, was_run, was_pause, at_lim;
    int fb;
    if (!rst) begin
      m_phase = 0; m_speed = 0; m_up = 1; m_db = 0; m_clr = 0; m_lit = 1;
      m_lvl = 0; m_press = 0; m_cnt = '{0, 0, 0};
    end else begin
      r = {btn_dir, btn_mode, btn_run};
      nl = m_lvl;
      if (ena1khz)
        for (int i = 0; i < 3; i++) begin
          if (r[i] != m_lvl[i]) begin
            m_cnt[i]++;
            if (m_cnt[i] == DB) begin nl[i] = r[i]; m_cnt[i] = 0; end
          end else m_cnt[i] = 0;
        end
      ev = m_press;
      m_press = nl & ~m_lvl;
      m_lvl = nl;
      tk = {ena1hz, ena2hz, ena5hz, ena10hz};
      tick = tk[m_speed];
      was_run = m_phase == 1;
      was_pause = m_phase == 2;
      fb = (chuc <= 9 && donvi <= 9) ? chuc * 10 + donvi : -1;
      m_clr = 0; m_db = 0;
      if (ev[1]) m_speed = (m_speed + 1) % 4;
      if (ev[0] && ev[2]) begin
        m_phase = 0; m_clr = 1; m_up = 1;
      end else begin
        at_lim = was_run && tick && (m_up ? fb == 99 : fb == 0);
        m_db = was_run && tick && !at_lim;
        if (at_lim || ev[2]) m_up = !m_up;
        if (ev[0]) m_phase = was_run ? 2 : 1;
      end
      if (m_phase != 2) m_lit = 1;
      else if (was_pause && ena2hz) m_lit = !m_lit;
    end
  end

  function automatic logic [15:0] pack(input logic [1:0] st, input logic [1:0] sp, input logic d, input logic b, input logic c, input logic [7:0] l);
    return {st, sp, d, b, c, l, 1'b0};
  endfunction

  // Per-cycle comparison against the model
  always @(negedge ckht) if (chk_en) begin
    logic [1:0] est;
    logic [15:0] exp_v, act_v;
    est = m_phase == 1 ? (m_up ? 2'd1 : 2'd2) : m_phase == 2 ? 2'd3 : 2'd0;
    exp_v = pack(est, 2'(m_speed), m_up, m_db, m_clr, m_lit ? 8'h03 : 8'h00);
    act_v = pack(state, speed_sel, dir_up, ena_db, clr, ena_8led);
    n_chk++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL model t=%0t got st=%0d sp=%0d dir=%0b db=%0b clr=%0b led=%h want st=%0d sp=%0d dir=%0b db=%0b clr=%0b led=%h",
        $time, state, speed_sel, dir_up, ena_db, clr, ena_8led, est, m_speed, m_up, m_db, m_clr, m_lit ? 8'h03 : 8'h00);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, act, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge ckht);
  endtask

  task automatic khz_tick;
    ena1khz = 1; cyc(1); ena1khz = 0; cyc(1);
  endtask

  task automatic press(input logic [2:0] m);
    {btn_dir, btn_mode, btn_run} = m;
    repeat (DB) khz_tick();
    cyc(2);
    {btn_dir, btn_mode, btn_run} = 3'b000;
    repeat (DB) khz_tick();
    cyc(2);
  endtask

  initial begin
    cyc(1);
    chk_en = 1;
    cyc(2);
    chk("rst_state", {6'd0, state}, 8'd0);
    chk("rst_speed", {6'd0, speed_sel}, 8'd0);
    chk("rst_dir", {7'd0, dir_up}, 8'd1);
    chk("rst_db", {7'd0, ena_db}, 8'd0);
    chk("rst_clr", {7'd0, clr}, 8'd0);
    chk("rst_led", ena_8led, 8'h03);
    rst = 1;
    cyc(2);
    btn_run = 1;
    repeat (DB - 1) khz_tick();
    btn_run = 0;
    repeat (2) khz_tick();
    cyc(2);
    chk("glitch_state", {6'd0, state}, 8'd0);
    btn_run = 1;
    repeat (DB - 1) khz_tick();
    ena1khz = 1; cyc(1); ena1khz = 0;
    chk("db_before", {6'd0, state}, 8'd0);
    cyc(1);
    chk("db_after", {6'd0, state}, 8'd1);
    btn_run = 0;
    repeat (DB) khz_tick();
    cyc(2);
    repeat (3) press(3'b010);
    chk("speed3", {6'd0, speed_sel}, 8'd3);
    for (int k = 0; k < 5; k++) begin
      ena1hz = 1; cyc(1); ena1hz = 0;
      chk("rate_pulse", {7'd0, ena_db}, 8'd1);
      cyc(1);
      chk("rate_single", {7'd0, ena_db}, 8'd0);
      ena10hz = 1; cyc(1); ena10hz = 0;
      chk("rate_10hz", {7'd0, ena_db}, 8'd0);
      cyc(1);
    end
    press(3'b001);
    chk("pause_state", {6'd0, state}, 8'd3);
    chk("pause_db", {7'd0, ena_db}, 8'd0);
    for (int k = 0; k < 4; k++) begin
      ena2hz = 1; cyc(1); ena2hz = 0;
      chk("blink", ena_8led, k % 2 == 0 ? 8'h00 : 8'h03);
      cyc(2);
    end
    press(3'b001);
    chk("resume_state", {6'd0, state}, 8'd1);
    chk("resume_led", ena_8led, 8'h03);
    chuc = 4'd9; donvi = 4'd9;
    ena1hz = 1; cyc(1); ena1hz = 0;
    chk("rev99_db", {7'd0, ena_db}, 8'd0);
    chk("rev99_dir", {7'd0, dir_up}, 8'd0);
    chk("rev99_state", {6'd0, state}, 8'd2);
    cyc(2);
    chuc = 4'd0; donvi = 4'd0;
    ena1hz = 1; cyc(1); ena1hz = 0;
    chk("rev00_db", {7'd0, ena_db}, 8'd0);
    chk("rev00_dir", {7'd0, dir_up}, 8'd1);
    chk("rev00_state", {6'd0, state}, 8'd1);
    cyc(2);
    chuc = 4'd9; donvi = 4'hA;
    ena1hz = 1; cyc(1); ena1hz = 0;
    chk("badbcd_db", {7'd0, ena_db}, 8'd1);
    cyc(2);
    chuc = 4'd5; donvi = 4'd5;
    press(3'b100);
    chk("dn_state", {6'd0, state}, 8'd2);
    repeat (3) press(3'b010);
    chk("speed2", {6'd0, speed_sel}, 8'd2);
    {btn_dir, btn_mode, btn_run} = 3'b101;
    repeat (DB - 1) khz_tick();
    ena1khz = 1; cyc(1); ena1khz = 0;
    ena2hz = 1; cyc(1); ena2hz = 0;
    chk("clr_pulse", {7'd0, clr}, 8'd1);
    chk("clr_state", {6'd0, state}, 8'd0);
    chk("clr_dir", {7'd0, dir_up}, 8'd1);
    chk("clr_speed", {6'd0, speed_sel}, 8'd2);
    chk("clr_db", {7'd0, ena_db}, 8'd0);
    cyc(1);
    chk("clr_single", {7'd0, clr}, 8'd0);
    {btn_dir, btn_mode, btn_run} = 3'b000;
    repeat (DB) khz_tick();
    press(3'b001);
    chk("rerun_state", {6'd0, state}, 8'd1);
    rst = 0; cyc(1); rst = 1;
    chk("midrst_state", {6'd0, state}, 8'd0);
    chk("midrst_speed", {6'd0, speed_sel}, 8'd0);
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
